// File: rtl/texture_mem_arbiter.sv
`default_nettype none
// texture_mem_arbiter: single-port texture RAM arbiter, pixel priority with a bounded CPU wait.
// Build option: define TEXARB_STALL_CNT_EN to include the saturating cpu_stall_cnt counter.
module texture_mem_arbiter #(
  parameter int DATA_W       = 24,
  parameter int ADDR_W       = 14,
  parameter int DEPTH        = 13312,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              px_req,
  input  logic [ADDR_W-1:0] px_addr,
  output logic              px_gnt,
  output logic              px_valid,
  output logic [DATA_W-1:0] px_data,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [15:0]       cpu_stall_cnt
);

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  logic [3:0]        wait_cnt;
  logic              cpu_win;
  logic              any_gnt;
  logic              gnt_read;
  logic              in_range;
  logic [ADDR_W-1:0] gnt_addr;

  // tag pipeline: stage 1 aligns with the RAM access, stage 2 with its read data
  logic              s1_vld, s1_cpu, s1_oor;
  logic              s2_vld, s2_cpu, s2_oor;
  logic [DATA_W-1:0] rd_data;

  // Grants are held low during reset so every output reads 0 while reset is low.
  assign cpu_win  = reset & cpu_req & (~px_req | (wait_cnt == MAX_WAIT));
  assign cpu_gnt  = cpu_win;
  assign px_gnt   = reset & px_req & ~cpu_win;

  assign any_gnt  = px_gnt | cpu_gnt;
  assign gnt_read = px_gnt | (cpu_gnt & ~cpu_we);
  assign gnt_addr = cpu_gnt ? cpu_addr : px_addr;
  assign in_range = (32'(gnt_addr) < 32'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (cpu_req && !cpu_gnt) begin
      if (wait_cnt < MAX_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      s1_vld    <= 1'b0;
      s1_cpu    <= 1'b0;
      s1_oor    <= 1'b0;
      s2_vld    <= 1'b0;
      s2_cpu    <= 1'b0;
      s2_oor    <= 1'b0;
    end else begin
      // out-of-range accesses never reach the RAM; reads still complete with zero data
      mem_en <= any_gnt & in_range;
      mem_we <= cpu_gnt & cpu_we & in_range;
      if (any_gnt) begin
        mem_addr  <= gnt_addr;
        mem_wdata <= cpu_gnt ? cpu_wdata : '0;
      end
      s1_vld <= gnt_read;
      s1_cpu <= cpu_gnt;
      s1_oor <= ~in_range;
      s2_vld <= s1_vld;
      s2_cpu <= s1_cpu;
      s2_oor <= s1_oor;
    end
  end

  assign rd_data   = s2_oor ? '0 : mem_rdata;
  assign px_valid  = s2_vld & ~s2_cpu;
  assign cpu_valid = s2_vld & s2_cpu;
  assign px_data   = px_valid  ? rd_data : '0;
  assign cpu_rdata = cpu_valid ? rd_data : '0;

`ifdef TEXARB_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (cpu_req && !cpu_gnt && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign cpu_stall_cnt = stall_cnt;
`else
  assign cpu_stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
